lives_text_renderer: RTL
========================

Name: lives_text_renderer

Overview:
- Reader side of the "LIVES:" glyph ROM: converts VGA pixel coordinates into ROM row addresses, samples the returned 8-bit glyph rows and produces a registered pixel-on flag for the colour mapper.
- Also owns the player lives counter, and a blink state machine that flashes the label for a number of frames after a life is lost.
- Sits between the VGA controller (DrawX/DrawY, frame pulse), the game logic (life_lost, new_game) and the colour mapper.

Parameters:
- TEXT_X, 16, left pixel column of the 48x16 text window.
- TEXT_Y, 8, top pixel row of the text window.
- START_LIVES, 3, lives loaded at reset and on new_game (1..7).
- BLINK_FRAMES, 60, frames the label blinks after a life is lost (1..255).

Ports:
- Clk, input, 1, pixel clock.
- Reset, input, 1, asynchronous active-high reset.
- DrawX, input, 10, current pixel column.
- DrawY, input, 10, current pixel row.
- frame_start, input, 1, one-cycle pulse per frame (start of vertical blank).
- life_lost, input, 1, one-cycle pulse: player hit.
- new_game, input, 1, one-cycle pulse: reload lives.
- rom_addr, output, 8, registered address to the glyph ROM.
- rom_data, input, 8, combinational ROM row for rom_addr; bit 7 is the leftmost pixel.
- text_on, output, 1, registered: the current (delayed) pixel is a lit label pixel.
- lives, output, 3, current lives count.
- game_over, output, 1, high when lives == 0.

Behaviour:
- Reset (async, active-high) sets: rom_addr=0, text_on=0, lives=START_LIVES, game_over=0, state=IDLE, blink counter=0, all pipeline registers 0.
- Window hit: TEXT_X <= DrawX < TEXT_X+48 and TEXT_Y <= DrawY < TEXT_Y+16. Compute dx=DrawX-TEXT_X and dy=DrawY-TEXT_Y, both unsigned, only meaningful on a hit.
- Glyph mapping: glyph = dx[5:3] (values 0..5 = L,I,V,E,S,:); col = dx[2:0]; row = dy[3:0].
- Address: glyph*16 + row, so the maximum is 95 and no address above 95 is ever driven.
- Pipeline stage 1 (cycle n+1): on a hit, rom_addr <= address; col and hit are registered alongside. On a miss, rom_addr <= 0 and hit_d <= 0.
- Pipeline stage 2 (cycle n+2): text_on <= hit_d & rom_data[7-col_d] & ~blank.
- Fixed latency: text_on is valid exactly 2 Clk after the DrawX/DrawY it belongs to. The consumer must delay DrawX/DrawY by 2 to align.
- Lives counter, priority order:
  - new_game: lives <= START_LIVES. Wins over a simultaneous life_lost.
  - Otherwise life_lost with lives > 0: lives <= lives-1.
  - life_lost with lives == 0: lives stays 0 (saturates, no wrap).
- game_over is combinational from the registered lives (lives == 0).
- Blink FSM, states IDLE and BLINK:
  - IDLE -> BLINK on an effective decrement (life_lost, lives > 0, no new_game). Loads bcnt <= BLINK_FRAMES and fcnt <= 0.
  - In BLINK, each frame_start does bcnt <= bcnt-1 and fcnt <= fcnt+1. The transition to IDLE happens on the frame_start that takes bcnt from 1 to 0.
  - A further effective decrement while in BLINK reloads bcnt <= BLINK_FRAMES and fcnt <= 0, staying in BLINK.
  - new_game forces IDLE from either state.
  - blank = (state == BLINK) & fcnt[3]: 8 frames lit, 8 frames dark.
  - frame_start and life_lost together: the life_lost reload wins.
- Reset mid-frame or mid-blink returns everything to reset values immediately. No partial pixel is emitted; text_on is 0 from reset onward until a new hit propagates.

Test Plan:
- After reset, drive (16,10) -> cycle+1: rom_addr=0x02. Return rom_data=0xF0 -> cycle+2: text_on=1. Drive (23,10) -> col 7 -> text_on=0.
- Drive (24,10) -> rom_addr=0x12 (glyph 1, row 2). Drive (61,13) -> rom_addr=0x55. Drive (64,10) or (20,24) -> rom_addr=0 and text_on=0 regardless of rom_data.
- Pulse life_lost 4 times -> lives 2,1,0,0. game_over rises after the third pulse. The fourth pulse leaves lives=0 and the state unchanged.
- life_lost with BLINK_FRAMES=20, then 20 frame_start pulses with a lit pixel held:
  - text_on=1 after frame pulses 0..7;
  - text_on=0 after pulses 8..15;
  - text_on=1 after pulses 16..19;
  - IDLE after the 20th pulse.
- new_game and life_lost in the same cycle with lives=1 -> lives=3, state=IDLE, game_over=0.
- Assert Reset mid-BLINK with lives=1 -> asynchronously: lives=3, text_on=0, rom_addr=0, state=IDLE.

Source files
------------

// File: rtl/lives_text_renderer_if.sv
// Bundle between the VGA/game side and the "LIVES:" label renderer.
// The master side drives pixel coordinates, game events and the ROM row.
interface lives_text_renderer_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;
  logic       life_lost;
  logic       new_game;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       text_on;
  logic [2:0] lives;
  logic       game_over;

  modport master (
    output DrawX, DrawY, frame_start, life_lost, new_game, rom_data,
    input  rom_addr, text_on, lives, game_over
  );

  modport slave (
    input  DrawX, DrawY, frame_start, life_lost, new_game, rom_data,
    output rom_addr, text_on, lives, game_over
  );
endinterface

// File: rtl/lives_text_renderer.sv
// Renders the 48x16 "LIVES:" label from a glyph ROM with a fixed two-cycle latency,
// and owns the lives counter plus the post-hit blink state machine.
module lives_text_renderer #(
  parameter int TEXT_X       = 16,
  parameter int TEXT_Y       = 8,
  parameter int START_LIVES  = 3,
  parameter int BLINK_FRAMES = 60
) (
  input logic Clk,
  input logic Reset,
  lives_text_renderer_if.slave bus
);

  localparam logic [9:0] X_LO       = 10'(TEXT_X);
  localparam logic [9:0] X_HI       = 10'(TEXT_X + 48);
  localparam logic [9:0] Y_LO       = 10'(TEXT_Y);
  localparam logic [9:0] Y_HI       = 10'(TEXT_Y + 16);
  localparam logic [2:0] LIVES_LOAD = 3'(START_LIVES);
  localparam logic [7:0] BLINK_LOAD = 8'(BLINK_FRAMES);

  typedef enum logic {IDLE, BLINK} state_t;

  state_t     state, state_next;
  logic [7:0] bcnt, bcnt_next;
  logic [7:0] fcnt, fcnt_next;
  logic [2:0] col_d;
  logic       hit_d;
  logic       blank;
  logic       hit;
  logic [5:0] dx;
  logic [3:0] dy;
  logic [2:0] lives_q;
  logic       dec;

  // Only the low bits of the offsets matter; upper bits are covered by the window compare.
  assign hit = (bus.DrawX >= X_LO) && (bus.DrawX < X_HI) &&
               (bus.DrawY >= Y_LO) && (bus.DrawY < Y_HI);
  assign dx  = bus.DrawX[5:0] - X_LO[5:0];
  assign dy  = bus.DrawY[3:0] - Y_LO[3:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.rom_addr <= 8'd0;
      col_d        <= 3'd0;
      hit_d        <= 1'b0;
      bus.text_on  <= 1'b0;
    end else begin
      if (hit) begin
        bus.rom_addr <= {1'b0, dx[5:3], dy};
        hit_d        <= 1'b1;
      end else begin
        bus.rom_addr <= 8'd0;
        hit_d        <= 1'b0;
      end
      col_d       <= dx[2:0];
      bus.text_on <= hit_d & bus.rom_data[3'd7 - col_d] & ~blank;
    end
  end

  // An effective decrement is the only event that (re)starts the blink.
  assign dec = bus.life_lost & ~bus.new_game & (lives_q != 3'd0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      lives_q <= LIVES_LOAD;
    else if (bus.new_game)
      lives_q <= LIVES_LOAD;
    else if (dec)
      lives_q <= lives_q - 3'd1;
  end

  assign bus.lives     = lives_q;
  assign bus.game_over = (lives_q == 3'd0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      bcnt  <= 8'd0;
      fcnt  <= 8'd0;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
      fcnt  <= fcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    fcnt_next  = fcnt;
    if (bus.new_game) begin
      state_next = IDLE;
      bcnt_next  = 8'd0;
      fcnt_next  = 8'd0;
    end else if (dec) begin
      state_next = BLINK;
      bcnt_next  = BLINK_LOAD;
      fcnt_next  = 8'd0;
    end else if (state == BLINK && bus.frame_start) begin
      bcnt_next = bcnt - 8'd1;
      fcnt_next = fcnt + 8'd1;
      if (bcnt == 8'd1)
        state_next = IDLE;
    end
  end

  always_comb begin
    blank = (state == BLINK) & fcnt[3];
  end

endmodule
